// File: rtl/error_block_if.sv
// Sample-point strobe, active-low error indications and aggregated error outputs of error_block.
// With ERROR_BLOCK_CNT_EN defined the bundle also carries the saturating error count ERR_CNT.
interface error_block_if
`ifdef ERROR_BLOCK_CNT_EN
  #(parameter int unsigned CNT_W = 8)
`endif
  ;
  logic       SP;
  logic       STF_E;
  logic       EOF_E;
  logic       CRC_E;
  logic       FRM_E;
  logic       ERROR;
  logic       ERR_DET;
  logic [3:0] ERR_TYPE;
`ifdef ERROR_BLOCK_CNT_EN
  logic [CNT_W-1:0] ERR_CNT;
`endif

  modport master (
    output SP, STF_E, EOF_E, CRC_E, FRM_E,
    input  ERROR, ERR_DET, ERR_TYPE
`ifdef ERROR_BLOCK_CNT_EN
    , input ERR_CNT
`endif
  );

  modport slave (
    input  SP, STF_E, EOF_E, CRC_E, FRM_E,
    output ERROR, ERR_DET, ERR_TYPE
`ifdef ERROR_BLOCK_CNT_EN
    , output ERR_CNT
`endif
  );
endinterface

// File: rtl/error_block.sv
// CAN error aggregation: samples active-low error inputs on SP and holds ERROR for FLAG_LEN sample points.
// Optional saturating error-event counter ERR_CNT enabled by macro ERROR_BLOCK_CNT_EN.
module error_block #(
  parameter int unsigned FLAG_LEN = 6
`ifdef ERROR_BLOCK_CNT_EN
  , parameter int unsigned CNT_W = 8
`endif
) (
  input  logic          clock,
  input  logic          reset,
  error_block_if.slave  bus
);
  localparam int unsigned FLAG_W = 4;

  typedef enum logic {IDLE, FLAG} state_t;

  state_t              state_q, state_d;
  logic [FLAG_W-1:0]   flag_cnt_q, flag_cnt_d;
  logic                error_q, error_d;
  logic                err_det_q, err_det_d;
  logic [3:0]          err_type_q, err_type_d;
  logic [3:0]          err_vec;
`ifdef ERROR_BLOCK_CNT_EN
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  assign err_vec = ~{bus.STF_E, bus.EOF_E, bus.CRC_E, bus.FRM_E};

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      flag_cnt_q <= '0;
      error_q    <= 1'b0;
      err_det_q  <= 1'b0;
      err_type_q <= '0;
`ifdef ERROR_BLOCK_CNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      flag_cnt_q <= flag_cnt_d;
      error_q    <= error_d;
      err_det_q  <= err_det_d;
      err_type_q <= err_type_d;
`ifdef ERROR_BLOCK_CNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next-state and next-output logic; inputs only matter on sample points
  always_comb begin
    state_d    = state_q;
    flag_cnt_d = flag_cnt_q;
    error_d    = error_q;
    err_det_d  = 1'b0;
    err_type_d = err_type_q;
`ifdef ERROR_BLOCK_CNT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.SP && (err_vec != 4'b0000)) begin
          state_d    = FLAG;
          flag_cnt_d = FLAG_W'(FLAG_LEN);
          error_d    = 1'b1;
          err_det_d  = 1'b1;
          err_type_d = err_vec;
`ifdef ERROR_BLOCK_CNT_EN
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      FLAG: begin
        if (bus.SP) begin
          flag_cnt_d = flag_cnt_q - FLAG_W'(1);
          if (flag_cnt_q == FLAG_W'(1)) begin
            error_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ERROR    = error_q;
  assign bus.ERR_DET  = err_det_q;
  assign bus.ERR_TYPE = err_type_q;
`ifdef ERROR_BLOCK_CNT_EN
  assign bus.ERR_CNT  = cnt_q;
`endif
endmodule

// File: tb/tb_error_block.sv
// Self-checking bench for error_block: directed scenarios plus randomized traffic against a flag-window model.
// Counter checks are compiled in when ERROR_BLOCK_CNT_EN is defined.
module tb_error_block;
  localparam int FLAG_LEN = 6;
  localparam logic [3:0] CLEAN = 4'b1111;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  // Reference model: sample points remaining in the current flag, last captured cause, event count
  logic       m_error;
  logic       m_det;
  logic [3:0] m_type;
  int         m_left;
  int         m_cnt;

  error_block_if bus ();

  error_block #(.FLAG_LEN(FLAG_LEN)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_error = 1'b0;
    m_det   = 1'b0;
    m_type  = 4'b0000;
    m_left  = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic sp, input logic [3:0] e);
    m_det = 1'b0;
    if (!reset) begin
      model_reset();
    end else if (sp) begin
      if (m_left > 0) begin
        m_left = m_left - 1;
        m_error = (m_left > 0);
      end else if (e != CLEAN) begin
        m_error = 1'b1;
        m_det   = 1'b1;
        m_type  = ~e;
        m_left  = FLAG_LEN;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Drive one clock with the given strobe and {STF,EOF,CRC,FRM} levels; outputs settle #1 after the edge
  task automatic tick(input logic sp, input logic [3:0] e);
    bus.SP = sp;
    {bus.STF_E, bus.EOF_E, bus.CRC_E, bus.FRM_E} = e;
    @(posedge clock);
    #1;
    model_step(sp, e);
  endtask

  task automatic do_reset();
    bus.SP = 1'b0;
    {bus.STF_E, bus.EOF_E, bus.CRC_E, bus.FRM_E} = CLEAN;
    reset = 1'b0;
    #2;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'(i % 2), 4'b0000);
      checks++;
      if (bus.ERROR !== 1'b0 || bus.ERR_DET !== 1'b0 || bus.ERR_TYPE !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got err=%b det=%b type=%b exp 0/0/0000", i, bus.ERROR, bus.ERR_DET, bus.ERR_TYPE);
      end
`ifdef ERROR_BLOCK_CNT_EN
      checks++;
      if (bus.ERR_CNT !== 8'd0) begin
        failures++;
        $display("FAIL reset_cnt got=%0d exp=0", bus.ERR_CNT);
      end
`endif
    end
    {bus.STF_E, bus.EOF_E, bus.CRC_E, bus.FRM_E} = CLEAN;
    bus.SP = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_single_stuff();
    do_reset();
    tick(1'b1, 4'b0111);
    checks++;
    if (bus.ERROR !== 1'b1 || bus.ERR_DET !== 1'b1 || bus.ERR_TYPE !== 4'b1000) begin
      failures++;
      $display("FAIL stuff_detect got err=%b det=%b type=%b exp 1/1/1000", bus.ERROR, bus.ERR_DET, bus.ERR_TYPE);
    end
    tick(1'b0, CLEAN);
    checks++;
    if (bus.ERROR !== 1'b1 || bus.ERR_DET !== 1'b0) begin
      failures++;
      $display("FAIL stuff_det_pulse got err=%b det=%b exp 1/0", bus.ERROR, bus.ERR_DET);
    end
    for (int k = 1; k <= FLAG_LEN; k++) begin
      tick(1'b1, CLEAN);
      checks++;
      if (bus.ERROR !== ((k < FLAG_LEN) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL stuff_flag sp=%0d got=%b exp=%b", k, bus.ERROR, (k < FLAG_LEN));
      end
      tick(1'b0, CLEAN);
    end
  endtask

  task automatic test_sequence();
    logic [3:0] pats [3];
    int n;
    pats[0] = 4'b1011;
    pats[1] = 4'b1101;
    pats[2] = 4'b1110;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      tick(1'b0, CLEAN);
      tick(1'b1, pats[p]);
      checks++;
      if (bus.ERROR !== 1'b1 || bus.ERR_TYPE !== ~pats[p]) begin
        failures++;
        $display("FAIL seq_type p=%0d got err=%b type=%b exp 1/%b", p, bus.ERROR, bus.ERR_TYPE, ~pats[p]);
      end
      n = 0;
      while (bus.ERROR === 1'b1 && n < 20) begin
        tick(1'b1, CLEAN);
        n++;
      end
      checks++;
      if (n != FLAG_LEN) begin
        failures++;
        $display("FAIL seq_flag_len p=%0d got=%0d exp=%0d", p, n, FLAG_LEN);
      end
      for (int c = 0; c < 7; c++) tick(1'b1, CLEAN);
    end
`ifdef ERROR_BLOCK_CNT_EN
    checks++;
    if (bus.ERR_CNT !== 8'd3) begin
      failures++;
      $display("FAIL seq_cnt got=%0d exp=3", bus.ERR_CNT);
    end
`endif
  endtask

  task automatic test_glitch();
    do_reset();
    tick(1'b1, 4'b1110);
    for (int c = 0; c < FLAG_LEN + 2; c++) tick(1'b1, CLEAN);
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 4'b1101);
      checks++;
      if (bus.ERROR !== 1'b0 || bus.ERR_DET !== 1'b0 || bus.ERR_TYPE !== 4'b0001) begin
        failures++;
        $display("FAIL glitch got err=%b det=%b type=%b exp 0/0/0001", bus.ERROR, bus.ERR_DET, bus.ERR_TYPE);
      end
    end
    tick(1'b1, CLEAN);
    checks++;
    if (bus.ERROR !== 1'b0 || bus.ERR_TYPE !== 4'b0001) begin
      failures++;
      $display("FAIL glitch_after got err=%b type=%b exp 0/0001", bus.ERROR, bus.ERR_TYPE);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    tick(1'b1, 4'b0110);
    checks++;
    if (bus.ERR_TYPE !== 4'b1001 || bus.ERR_DET !== 1'b1) begin
      failures++;
      $display("FAIL simul_type got type=%b det=%b exp 1001/1", bus.ERR_TYPE, bus.ERR_DET);
    end
    n = 0;
    while (bus.ERROR === 1'b1 && n < 20) begin
      tick(1'b1, (n == 2) ? 4'b1011 : CLEAN);
      n++;
      checks++;
      if (bus.ERR_DET !== 1'b0 || bus.ERR_TYPE !== 4'b1001) begin
        failures++;
        $display("FAIL simul_inflag sp=%0d got det=%b type=%b exp 0/1001", n, bus.ERR_DET, bus.ERR_TYPE);
      end
    end
    checks++;
    if (n != FLAG_LEN) begin
      failures++;
      $display("FAIL simul_flag_len got=%0d exp=%0d", n, FLAG_LEN);
    end
  endtask

  task automatic test_reset_mid_flag();
    do_reset();
    tick(1'b1, 4'b0111);
    tick(1'b1, CLEAN);
    checks++;
    if (bus.ERROR !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got=%b exp=1", bus.ERROR);
    end
    bus.SP = 1'b1;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.ERROR !== 1'b0 || bus.ERR_DET !== 1'b0 || bus.ERR_TYPE !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_async got err=%b det=%b type=%b exp 0/0/0000", bus.ERROR, bus.ERR_DET, bus.ERR_TYPE);
    end
`ifdef ERROR_BLOCK_CNT_EN
    checks++;
    if (bus.ERR_CNT !== 8'd0) begin
      failures++;
      $display("FAIL midrst_cnt got=%0d exp=0", bus.ERR_CNT);
    end
`endif
    tick(1'b1, CLEAN);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick(1'(c % 2), CLEAN);
      checks++;
      if (bus.ERROR !== 1'b0) begin
        failures++;
        $display("FAIL midrst_after cyc=%0d got=%b exp=0", c, bus.ERROR);
      end
    end
  endtask

  task automatic test_random();
    logic       sp;
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      sp = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 4; b++) e[b] = ($urandom_range(0, 9) != 0);
      tick(sp, e);
      checks++;
      if (bus.ERROR !== m_error || bus.ERR_DET !== m_det || bus.ERR_TYPE !== m_type) begin
        failures++;
        $display("FAIL random cyc=%0d got err=%b det=%b type=%b exp %b/%b/%b",
                 c, bus.ERROR, bus.ERR_DET, bus.ERR_TYPE, m_error, m_det, m_type);
      end
`ifdef ERROR_BLOCK_CNT_EN
      checks++;
      if (bus.ERR_CNT !== 8'(m_cnt)) begin
        failures++;
        $display("FAIL random_cnt cyc=%0d got=%0d exp=%0d", c, bus.ERR_CNT, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.SP   = 1'b0;
    {bus.STF_E, bus.EOF_E, bus.CRC_E, bus.FRM_E} = CLEAN;
    model_reset();
    test_reset();
    test_single_stuff();
    test_sequence();
    test_glitch();
    test_simultaneous();
    test_reset_mid_flag();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/error_block.md
Name: error_block

Overview:
- Error aggregation block of the CAN decoder.
- At each bit sample point it samples four active-low error indications from the decoder sub-blocks: stuff, end-of-frame, CRC and form.
- On any error it raises ERROR for the length of a CAN error flag and records which errors occurred.
- ERROR feeds the frame FSM and error-frame generation logic.

Parameters:
- FLAG_LEN, 6, number of sample points ERROR is held high after detection (range 1..15).
- CNT_W, 8, width of the optional error counter.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- SP  input  1  sample-point strobe, one clock wide per CAN bit.
- STF_E  input  1  stuff error, active-low (0 = error).
- EOF_E  input  1  end-of-frame error, active-low.
- CRC_E  input  1  CRC error, active-low.
- FRM_E  input  1  form error, active-low.
- ERROR  output  1  error flag, active-high, registered.
- ERR_DET  output  1  one-clock pulse on the cycle after detection.
- ERR_TYPE  output  4  captured error causes, active-high: [3]=stuff, [2]=EOF, [1]=CRC, [0]=form.
- ERR_CNT  output  CNT_W  error event count; present only with the optional feature.

Behaviour:
- Reset (reset=0, asynchronous): ERROR=0, ERR_DET=0, ERR_TYPE=0, internal flag counter=0, ERR_CNT=0. Outputs stay there while reset is low.
- Error inputs are evaluated only on rising clock edges where SP=1. Between sample points they are ignored, including glitches.
- Two states: IDLE and FLAG.
- IDLE, SP=1, at least one error input low:
  - next edge: ERROR=1, ERR_DET=1 for exactly one clock;
  - ERR_TYPE = bitwise inverse of {STF_E,EOF_E,CRC_E,FRM_E}, so simultaneous errors set several bits;
  - flag counter loaded with FLAG_LEN; go to FLAG.
  - Latency from SP edge to ERROR high: 1 clock.
- IDLE, SP=1, all inputs high: no change. ERR_TYPE keeps its last value.
- FLAG:
  - each SP=1 edge decrements the flag counter;
  - when it reaches 0 on an SP edge, ERROR clears on that edge and the state returns to IDLE;
  - ERROR is therefore high for exactly FLAG_LEN sample points, counted from the first SP after detection.
  - Error inputs are ignored in FLAG (no re-trigger, no ERR_TYPE update, no ERR_DET).
- SP=0: no state change except reset.
- First sample point after returning to IDLE is evaluated normally. Back-to-back errors produce back-to-back flags separated by one IDLE sample.
- Reset asserted mid-flag: immediate return to the reset values above.
- All outputs are driven from flops; no combinational input-to-output path.

Optional Feature:
- Macro ERROR_BLOCK_CNT_EN.
- Defined:
  - ERR_CNT port exists;
  - increments by 1 on each detection (same edge ERR_DET asserts);
  - saturates at 2^CNT_W-1;
  - cleared only by reset.
- Not defined: ERR_CNT port and counter logic absent; all other behaviour identical.

Test Plan:
- Reset: hold reset=0 with all error inputs 0 and SP pulsing -> ERROR=0, ERR_TYPE=0000, ERR_DET=0, ERR_CNT=0 throughout.
- Single stuff error: SP=1 with STF_E=0, others 1 -> next clock ERROR=1, ERR_DET=1 for one clock, ERR_TYPE=1000. ERROR falls on the 6th subsequent SP edge.
- Sequence EOF, CRC, FRM errors, each separated by at least 7 clean sample points -> ERR_TYPE=0100, then 0010, then 0001. Each flag lasts 6 sample points; ERR_CNT=3 with macro.
- Off-sample glitch: CRC_E=0 only while SP=0 -> ERROR stays 0, ERR_TYPE unchanged.
- Simultaneous errors plus in-flag error: STF_E=0 and FRM_E=0 on one SP -> ERR_TYPE=1001. EOF_E=0 at the 3rd SP during the flag -> ignored; ERR_TYPE stays 1001 and flag length stays 6.
- Reset mid-flag: reset=0 at the 2nd flag SP -> ERROR=0 immediately. After release with clean inputs, ERROR stays 0.
